// File: rtl/load_store_unit.sv
// load_store_unit: turns RISC-V loads/stores into word accesses on a word-only data memory.
// Sub-word stores do a read-modify-write; loads are lane-selected and extended.
module load_store_unit #(
  parameter bit AlignMemAddress = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ReqValid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  output logic        Ready,
  output logic        Done,
  output logic        Misaligned,
  output logic [31:0] LoadData,
  output logic        MemWriteEnable,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData
);
  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_READ, RMW_WRITE} state_t;
  state_t state, state_next;
  logic [31:0] addr, sdata, merged, merge_val, load_val;
  logic [2:0] f3;
  logic rd_only, wr_only, f3_ok, align_ok, take, accept, reject;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  assign rd_only  = MemRead & ~MemWrite;
  assign wr_only  = MemWrite & ~MemRead;
  assign f3_ok    = rd_only ? Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}
                            : Funct3 inside {3'b000, 3'b001, 3'b010};
  assign align_ok = (Funct3[1:0] == 2'b01) ? ~Address[0] :
                    (Funct3[1:0] == 2'b10) ? (Address[1:0] == 2'b00) : 1'b1;
  assign take     = ReqValid & (state == IDLE);
  assign accept   = take & (rd_only | wr_only) & f3_ok & align_ok;
  assign reject   = take & ~accept;
  always_comb begin
    state_next = (state == IDLE)     ? (accept ? (rd_only ? LOAD : Funct3[1] ? STORE : RMW_READ) : IDLE) :
                 (state == RMW_READ) ? RMW_WRITE : IDLE;
  end
  assign byte_sel = MemReadData[{addr[1:0], 3'b000} +: 8];
  assign half_sel = MemReadData[{addr[1], 4'b0000} +: 16];
  assign load_val = (f3[1:0] == 2'b00) ? {{24{~f3[2] & byte_sel[7]}}, byte_sel} :
                    (f3[1:0] == 2'b01) ? {{16{~f3[2] & half_sel[15]}}, half_sel} : MemReadData;
  // Only the addressed lane is replaced; the rest of the word comes back unchanged.
  always_comb begin
    merge_val = MemReadData;
    if (f3[0]) merge_val[{addr[1], 4'b0000} +: 16] = sdata[15:0];
    else merge_val[{addr[1:0], 3'b000} +: 8] = sdata[7:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      Done       <= 1'b0;
      Misaligned <= 1'b0;
      LoadData   <= '0;
      addr       <= '0;
      sdata      <= '0;
      f3         <= '0;
      merged     <= '0;
    end else begin
      state      <= state_next;
      Done       <= reject | (state inside {LOAD, STORE, RMW_WRITE});
      Misaligned <= reject & (MemRead | MemWrite);
      if (take) begin
        addr  <= Address;
        sdata <= StoreData;
        f3    <= Funct3;
      end
      if (state == LOAD) LoadData <= load_val;
      if (state == RMW_READ) merged <= merge_val;
    end
  end
  assign Ready          = (state == IDLE);
  assign MemWriteEnable = (state == STORE) | (state == RMW_WRITE);
  assign MemAddress     = Ready ? '0 : AlignMemAddress ? {addr[31:2], 2'b00} : addr;
  assign MemWriteData   = (state == STORE) ? sdata : (state == RMW_WRITE) ? merged : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed requests checked against a transaction-level model.
module tb_load_store_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] address = '0, store_data = '0;
  logic ready, done, misaligned, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
  bit [31:0] mem [64];
  bit [31:0] ref_mem [64];
  logic [31:0] last_ld = '0;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .ReqValid(req_valid), .MemRead(mem_read), .MemWrite(mem_write),
    .Funct3(funct3), .Address(address), .StoreData(store_data), .Ready(ready), .Done(done),
    .Misaligned(misaligned), .LoadData(load_data), .MemWriteEnable(mem_we),
    .MemAddress(mem_addr), .MemWriteData(mem_wdata), .MemReadData(mem_rdata)
  );

  assign mem_rdata = mem_we ? 32'h0 : mem[mem_addr[7:2]];
  always @(negedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Issues one request at a negedge with Ready=1 and returns at the negedge of its Done cycle.
  task automatic xact(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd);
    int exp_lat = 1, lat = 0, we_cnt = 0, exp_we = 0, off = 0, nb = 1;
    logic exp_mis = 1'b0;
    logic [5:0] idx = a[7:2];
    longint unsigned w = 64'(ref_mem[idx]), span, v, mask;
    bit legal, al;
    if (rd && wr) exp_mis = 1'b1;
    else if (rd || wr) begin
      legal = (f3 <= 3'd2) || (rd && (f3 == 3'd4 || f3 == 3'd5));
      al = (f3[1:0] == 2'd0) || (f3[1:0] == 2'd1 && a[0] == 1'b0) || (f3[1:0] == 2'd2 && a[1:0] == 2'd0);
      if (!legal || !al) exp_mis = 1'b1;
      else begin
        nb = (f3[1:0] == 2'd0) ? 1 : 2;
        off = (f3[1:0] == 2'd0) ? int'(a[1:0]) : 2 * int'(a[1]);
        span = 64'd1 << (8 * nb);
        if (rd) begin
          exp_lat = 2;
          if (f3[1:0] == 2'd2) last_ld = w[31:0];
          else begin
            v = (w >> (8 * off)) % span;
            if (!f3[2] && v >= span / 2) v += 64'h1_0000_0000 - span;
            last_ld = v[31:0];
          end
        end else begin
          exp_we = 1;
          if (f3[1:0] == 2'd2) begin
            exp_lat = 2;
            ref_mem[idx] = sd;
          end else begin
            exp_lat = 3;
            mask = (span - 1) << (8 * off);
            v = (w & ~mask) | ((64'(sd) << (8 * off)) & mask);
            ref_mem[idx] = v[31:0];
          end
        end
      end
    end
    chk("ready_at_issue", {31'b0, ready}, 32'd1);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; address = a; store_data = sd;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_we) we_cnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("latency", lat, exp_lat);
    chk("misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
    chk("load_data", load_data, last_ld);
    chk("we_cycles", we_cnt, exp_we);
    chk("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    #12;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_mis", {31'b0, misaligned}, 32'd0);
    chk("rst_load", load_data, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) xact(1'b0, 1'b1, 3'd2, 32'(i * 4), $urandom);
    xact(1'b0, 1'b1, 3'd2, 32'h10, 32'h8899AABB);
    xact(1'b1, 1'b0, 3'd0, 32'h11, 32'h0);
    chk("tp1_lb", load_data, 32'hFFFFFFAA);
    xact(1'b1, 1'b0, 3'd4, 32'h11, 32'h0);
    chk("tp1_lbu", load_data, 32'h000000AA);
    xact(1'b0, 1'b1, 3'd2, 32'h20, 32'h11223344);
    xact(1'b0, 1'b1, 3'd0, 32'h22, 32'h000000EE);
    chk("tp2_sb", mem[8], 32'h11EE3344);
    xact(1'b0, 1'b1, 3'd2, 32'h20, 32'h11223344);
    xact(1'b0, 1'b1, 3'd1, 32'h22, 32'h0000CAFE);
    chk("tp3_sh", mem[8], 32'hCAFE3344);
    xact(1'b1, 1'b0, 3'd1, 32'h22, 32'h0);
    chk("tp3_lh", load_data, 32'hFFFFCAFE);
    xact(1'b1, 1'b0, 3'd5, 32'h22, 32'h0);
    chk("tp3_lhu", load_data, 32'h0000CAFE);
    xact(1'b1, 1'b0, 3'd2, 32'h13, 32'h0);
    chk("tp4_lw_keep", load_data, 32'h0000CAFE);
    xact(1'b0, 1'b1, 3'd1, 32'h21, 32'h1234);
    xact(1'b0, 1'b1, 3'd2, 32'h30, 32'hDEADBEEF);
    xact(1'b1, 1'b0, 3'd2, 32'h30, 32'h0);
    chk("tp5_lw", load_data, 32'hDEADBEEF);
    for (int i = 0; i < 200; i++) begin
      int r = $urandom_range(0, 9);
      xact(r == 1 || (r >= 2 && r <= 5), r == 1 || r >= 6, 3'($urandom_range(0, 7)),
           32'($urandom_range(0, 255)), $urandom);
    end
    chk("pre_rst_ready", {31'b0, ready}, 32'd1);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'd0;
    address = 32'h40; store_data = 32'h000000A5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_we", {31'b0, mem_we}, 32'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rst_mid_done", {31'b0, done}, 32'd0);
      chk("rst_mid_we_hold", {31'b0, mem_we}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, ready}, 32'd1);
    chk("post_rst_done", {31'b0, done}, 32'd0);
    chk("post_rst_load", load_data, 32'd0);
    chk("post_rst_mem", mem[16], ref_mem[16]);
    last_ld = '0;
    xact(1'b1, 1'b0, 3'd2, 32'h40, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
